packet_disassembler: RTL and testbench

- Splits one wide response message into a sequence of narrow chunks, most-significant chunk first.
- Sits directly upstream of the SPI-side arbitrator. Each arbitrator input port is driven by one instance.
- Holds send_val continuously high for the whole message, so the arbitrator keeps its grant until the last chunk is accepted.
- Drops send_val for at least one cycle between messages, so the arbitrator can re-grant.

---
 rtl/packet_disassembler.sv | 77 +++++++
 tb/tb_packet_disassembler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/packet_disassembler.sv
// rtl/packet_disassembler.sv - splits one wide message into narrow chunks, MS chunk first
// send_val stays high for a whole message and drops for one IDLE cycle between messages.
module packet_disassembler #(
  parameter int n_bits_in  = 48,
  parameter int n_bits_out = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  recv_val,
  output logic                  recv_rdy,
  input  logic [n_bits_in-1:0]  recv_msg,
  output logic                  send_val,
  input  logic                  send_rdy,
  output logic [n_bits_out-1:0] send_msg
);

  localparam int n_chunks  = (n_bits_in + n_bits_out - 1) / n_bits_out;
  localparam int cnt_nbits = (n_chunks > 1) ? $clog2(n_chunks) : 1;
  localparam int n_pad     = n_chunks * n_bits_out;
  localparam logic [cnt_nbits-1:0] last_cnt = cnt_nbits'(n_chunks - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                 state_q, state_d;
  logic [cnt_nbits-1:0]   cnt_q, cnt_d;
  logic [n_pad-1:0]       shreg_q, shreg_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    // recv_rdy is gated by reset so it stays low while reset is held
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = '0;
    case (state_q)
      IDLE: begin
        recv_rdy = reset;
        if (recv_val && reset) begin
          shreg_d = n_pad'(recv_msg);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        send_val = 1'b1;
        send_msg = shreg_q[n_pad-1 -: n_bits_out];
        if (send_rdy) begin
          if (cnt_q == last_cnt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            shreg_d = shreg_q << n_bits_out;
            cnt_d   = cnt_q + cnt_nbits'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_packet_disassembler.sv
// tb/tb_packet_disassembler.sv - directed-vector bench for packet_disassembler
module tb_packet_disassembler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        recv_val = 1'b0;
  logic        recv_rdy;
  logic [47:0] recv_msg = '0;
  logic        send_val;
  logic        send_rdy = 1'b0;
  logic [15:0] send_msg;

  logic        recv_val_p = 1'b0;
  logic        recv_rdy_p;
  logic [39:0] recv_msg_p = '0;
  logic        send_val_p;
  logic        send_rdy_p = 1'b1;
  logic [15:0] send_msg_p;

  int n_vec = 0;
  int n_miscmp = 0;

  int          bp_rdy [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
  logic [15:0] bp_msg [8] = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,
                              16'hBBBB, 16'hBBBB, 16'hCCCC, 16'h0000};
  logic        bp_val [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  packet_disassembler #(.n_bits_in(48), .n_bits_out(16)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg)
  );

  packet_disassembler #(.n_bits_in(40), .n_bits_out(16)) dut_pad (
    .clk(clk), .reset(reset),
    .recv_val(recv_val_p), .recv_rdy(recv_rdy_p), .recv_msg(recv_msg_p),
    .send_val(send_val_p), .send_rdy(send_rdy_p), .send_msg(send_msg_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held with recv_val high
    recv_val = 1'b1;
    tick(); tick();
    check("rst_recv_rdy", recv_rdy, 0);
    check("rst_send_val", send_val, 0);
    check("rst_send_msg", send_msg, 0);
    recv_val = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_recv_rdy", recv_rdy, 1);
    check("idle_send_val", send_val, 0);

    // basic split, send_rdy tied high
    send_rdy = 1'b1;
    recv_val = 1'b1;
    recv_msg = 48'hAAAA_BBBB_CCCC;
    tick();
    recv_val = 1'b0;
    recv_msg = 48'hDEAD_BEEF_0000;
    check("basic_c1_val", send_val, 1);
    check("basic_c1_msg", send_msg, 16'hAAAA);
    check("basic_c1_rdy", recv_rdy, 0);
    tick();
    check("basic_c2_msg", send_msg, 16'hBBBB);
    tick();
    check("basic_c3_val", send_val, 1);
    check("basic_c3_msg", send_msg, 16'hCCCC);
    check("basic_c3_rdy", recv_rdy, 0);
    tick();
    check("basic_c4_val", send_val, 0);
    check("basic_c4_rdy", recv_rdy, 1);
    check("basic_c4_msg", send_msg, 0);

    // backpressure
    recv_val = 1'b1;
    recv_msg = 48'hAAAA_BBBB_CCCC;
    send_rdy = 1'b0;
    tick();
    recv_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_rdy = bp_rdy[i][0];
      check($sformatf("bp_c%0d_val", i + 1), send_val, bp_val[i]);
      check($sformatf("bp_c%0d_msg", i + 1), send_msg, bp_msg[i]);
      check($sformatf("bp_c%0d_rdy", i + 1), recv_rdy, !bp_val[i]);
      tick();
    end

    // back-to-back with recv_val held high
    send_rdy = 1'b1;
    recv_val = 1'b1;
    recv_msg = 48'h1111_2222_3333;
    tick();
    recv_msg = 48'h4444_5555_6666;
    check("b2b_c1_msg", send_msg, 16'h1111);
    tick();
    check("b2b_c2_msg", send_msg, 16'h2222);
    tick();
    check("b2b_c3_msg", send_msg, 16'h3333);
    check("b2b_c3_rdy", recv_rdy, 0);
    tick();
    check("b2b_c4_val", send_val, 0);
    check("b2b_c4_rdy", recv_rdy, 1);
    tick();
    recv_val = 1'b0;
    check("b2b_c5_val", send_val, 1);
    check("b2b_c5_msg", send_msg, 16'h4444);
    tick();
    check("b2b_c6_msg", send_msg, 16'h5555);
    tick();
    check("b2b_c7_msg", send_msg, 16'h6666);
    check("b2b_c7_val", send_val, 1);
    tick();
    check("b2b_c8_val", send_val, 0);

    // zero padding at the MSB with 40-bit input
    recv_val_p = 1'b1;
    recv_msg_p = 40'hAB_CDEF_1234;
    check("pad_idle_rdy", recv_rdy_p, 1);
    tick();
    recv_val_p = 1'b0;
    check("pad_c1_msg", send_msg_p, 16'h00AB);
    tick();
    check("pad_c2_msg", send_msg_p, 16'hCDEF);
    tick();
    check("pad_c3_msg", send_msg_p, 16'h1234);
    check("pad_c3_val", send_val_p, 1);
    tick();
    check("pad_c4_val", send_val_p, 0);

    // reset asserted after the first chunk is accepted
    send_rdy = 1'b1;
    recv_val = 1'b1;
    recv_msg = 48'hAAAA_BBBB_CCCC;
    tick();
    recv_val = 1'b0;
    check("mid_c1_msg", send_msg, 16'hAAAA);
    tick();
    check("mid_c2_msg", send_msg, 16'hBBBB);
    reset = 1'b0;
    #1;
    check("mid_async_val", send_val, 0);
    check("mid_async_msg", send_msg, 0);
    check("mid_async_rdy", recv_rdy, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_post%0d_val", i), send_val, 0);
      check($sformatf("mid_post%0d_rdy", i), recv_rdy, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
